// File: rtl/ram_dp_32x16384_pkg.sv
// -----------------------------------------------------------------------------
// Package: ram_dp_32x16384_pkg
// Purpose: Shared geometry of the 16384 x 32 tightly-coupled memories. The ITCM
//          and DTCM wrappers import this package so both memories stay the same
//          size as the RAM primitive below them.
// Contents:
//   RAM_WIDTH  data word width in bits
//   RAM_DEPTH  word address width in bits
//   RAM_WORDS  number of words (2**RAM_DEPTH)
//   ram_words_for()  word count implied by an address width
// -----------------------------------------------------------------------------
package ram_dp_32x16384_pkg;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 14;
  localparam int RAM_WORDS = 16384;

  // Word count addressed by an address of the given width. Wrappers use this
  // to size their own tables consistently with the RAM.
  function automatic int ram_words_for(input int depth);
    return 1 << depth;
  endfunction

endpackage : ram_dp_32x16384_pkg

// File: rtl/ram_dp_32x16384.sv
// -----------------------------------------------------------------------------
// Module: ram_dp_32x16384
// Purpose: True dual-port synchronous SRAM, 16384 words x 32 bits. It backs the
//          ITCM and DTCM of the RV32I core. Typically one port serves the CPU and
//          the other serves the loader or a read-modify-write write-back path.
//          The coding style keeps the array inferable as FPGA block RAM: the
//          array has no reset and there is no combinational read path.
// Ports:
//   clk      in   1      single clock; all activity on the rising edge
//   resetn   in   1      asynchronous active-low reset (clears rdata only)
//   rden_a   in   1      port A read enable
//   wren_a   in   1      port A full-word write enable
//   addr_a   in   DEPTH  port A word address
//   wdata_a  in   WIDTH  port A write data
//   rdata_a  out  WIDTH  port A registered read data (1-cycle latency)
//   rden_b   in   1      port B read enable
//   wren_b   in   1      port B full-word write enable
//   addr_b   in   DEPTH  port B word address
//   wdata_b  in   WIDTH  port B write data
//   rdata_b  out  WIDTH  port B registered read data (1-cycle latency)
// Behaviour notes:
//   - Read-first on both ports: a read in the same cycle as a write to the same
//     word (from either port) returns the old word.
//   - Both ports writing the same word in one cycle: port A's data is stored.
//   - Writes presented while resetn is low are dropped.
// -----------------------------------------------------------------------------
module ram_dp_32x16384
  import ram_dp_32x16384_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH,
  parameter int DEPTH = RAM_DEPTH,
  parameter int WORDS = RAM_WORDS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rden_a,
  input  logic             wren_a,
  input  logic [DEPTH-1:0] addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             rden_b,
  input  logic             wren_b,
  input  logic [DEPTH-1:0] addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic [WIDTH-1:0] rdata_b
);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [0:WORDS-1];

  // Qualified write strobes: a write only lands when the block is out of
  // reset at the sampling edge.
  logic we_a;
  logic we_b;

  // A port drives its output register on a read or on a write (the write
  // returns the word it replaces).
  logic ld_a;
  logic ld_b;

  assign we_a = wren_a & resetn;
  assign we_b = wren_b & resetn;
  assign ld_a = rden_a | wren_a;
  assign ld_b = rden_b | wren_b;

  // NOTE: the array carries no reset; clearing 16384 words is not possible in
  // one cycle and a reset term would stop the array mapping onto block RAM.
  // Port B's write is issued before port A's so that, for a same-word
  // collision, A's value is the last assignment and is the one kept.
  always_ff @(posedge clk) begin
    if (we_b) begin
      mem[addr_b] <= wdata_b;
    end
    if (we_a) begin
      mem[addr_a] <= wdata_a;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read ports
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments on both the array and the read registers
  // are what make the ports read-first: mem[] still holds the pre-edge word
  // when rdata samples it, regardless of which port is writing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_a <= '0;
    end else if (ld_a) begin
      rdata_a <= mem[addr_a];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_b <= '0;
    end else if (ld_b) begin
      rdata_b <= mem[addr_b];
    end
  end

endmodule : ram_dp_32x16384

// File: tb/tb_ram_dp_32x16384.sv
// -----------------------------------------------------------------------------
// Testbench: tb_ram_dp_32x16384
// Directed checks of ram_dp_32x16384: reset behaviour, basic write/read, hold,
// read-first collisions, dual-write priority, back-to-back streaming and a
// random fill from both ports compared against an associative-array model.
// -----------------------------------------------------------------------------
module tb_ram_dp_32x16384;

  logic        clk;
  logic        resetn;
  logic        rden_a;
  logic        wren_a;
  logic [13:0] addr_a;
  logic [31:0] wdata_a;
  logic [31:0] rdata_a;
  logic        rden_b;
  logic        wren_b;
  logic [13:0] addr_b;
  logic [31:0] wdata_b;
  logic [31:0] rdata_b;

  int checks = 0;
  int errors = 0;

  // Reference contents for every word the bench has written.
  logic [31:0] model [int];

  ram_dp_32x16384 dut (
    .clk     (clk),
    .resetn  (resetn),
    .rden_a  (rden_a),
    .wren_a  (wren_a),
    .addr_a  (addr_a),
    .wdata_a (wdata_a),
    .rdata_a (rdata_a),
    .rden_b  (rden_b),
    .wren_b  (wren_b),
    .addr_b  (addr_b),
    .wdata_b (wdata_b),
    .rdata_b (rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present one cycle of stimulus on both ports, take the rising edge and
  // return 1 time unit later so outputs are sampled away from the edge.
  task automatic apply(input logic ra, input logic wa, input logic [13:0] aa,
                       input logic [31:0] da, input logic rb, input logic wb,
                       input logic [13:0] ab, input logic [31:0] db);
    logic live;
    rden_a = ra; wren_a = wa; addr_a = aa; wdata_a = da;
    rden_b = rb; wren_b = wb; addr_b = ab; wdata_b = db;
    @(posedge clk);
    live = resetn;
    #1;
    if (live) begin
      if (wb) model[int'(ab)] = db;
      if (wa) model[int'(aa)] = da;
    end
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0);
  endtask

  initial begin
    logic [13:0] ra;
    logic [13:0] rb;
    int          keys [$];

    resetn = 1'b0;
    rden_a = 1'b0; wren_a = 1'b0; addr_a = '0; wdata_a = '0;
    rden_b = 1'b0; wren_b = 1'b0; addr_b = '0; wdata_b = '0;

    // ---- reset state -------------------------------------------------------
    idle();
    idle();
    check("reset_rdata_a", rdata_a, 32'h0);
    check("reset_rdata_b", rdata_b, 32'h0);
    resetn = 1'b1;

    // ---- preload: 0..7 = i*3, 0x0020 = 0x12345678 via B ---------------------
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 14'(i), 32'(i * 3), 1'b0, 1'b0, 14'h0, 32'h0);
    end
    apply(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b1, 14'h0020, 32'h12345678);

    // ---- basic write on A, read on B, hold ---------------------------------
    apply(1'b0, 1'b1, 14'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 14'h0, 32'h0);
    apply(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'h0010, 32'h0);
    check("basic_read_b", rdata_b, 32'hDEADBEEF);
    apply(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0005, 32'h0);
    apply(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0006, 32'h0);
    check("hold_rdata_b", rdata_b, 32'hDEADBEEF);

    // ---- read-first collision at the top word ------------------------------
    apply(1'b0, 1'b1, 14'h3FFF, 32'h11111111, 1'b0, 1'b0, 14'h0, 32'h0);
    apply(1'b0, 1'b1, 14'h3FFF, 32'h22222222, 1'b1, 1'b0, 14'h3FFF, 32'h0);
    check("collide_rdata_b_old", rdata_b, 32'h11111111);
    check("collide_rdata_a_old", rdata_a, 32'h11111111);
    apply(1'b1, 1'b0, 14'h3FFF, 32'h0, 1'b1, 1'b0, 14'h3FFF, 32'h0);
    check("collide_next_a", rdata_a, 32'h22222222);
    check("collide_next_b", rdata_b, 32'h22222222);

    // ---- dual write to 0x0100: A wins, both ports see the old word --------
    apply(1'b0, 1'b1, 14'h0100, 32'h0BADF00D, 1'b0, 1'b0, 14'h0, 32'h0);
    apply(1'b0, 1'b1, 14'h0100, 32'hAAAAAAAA, 1'b0, 1'b1, 14'h0100, 32'h55555555);
    check("dual_wr_old_a", rdata_a, 32'h0BADF00D);
    check("dual_wr_old_b", rdata_b, 32'h0BADF00D);
    apply(1'b1, 1'b0, 14'h0100, 32'h0, 1'b1, 1'b0, 14'h0100, 32'h0);
    check("dual_wr_read_a", rdata_a, 32'hAAAAAAAA);
    check("dual_wr_read_b", rdata_b, 32'hAAAAAAAA);

    // ---- back-to-back reads on B: 0,3,...,21 ------------------------------
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'(i), 32'h0);
      check($sformatf("stream_b[%0d]", i), rdata_b, 32'(i * 3));
    end

    // ---- asynchronous reset mid-operation ---------------------------------
    apply(1'b1, 1'b0, 14'h0010, 32'h0, 1'b1, 1'b0, 14'h3FFF, 32'h0);
    check("pre_reset_a", rdata_a, 32'hDEADBEEF);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_a", rdata_a, 32'h0);
    check("async_reset_b", rdata_b, 32'h0);
    // Writes and reads presented during reset must be ignored.
    apply(1'b1, 1'b1, 14'h0020, 32'hFFFFFFFF, 1'b1, 1'b1, 14'h0010, 32'hFFFFFFFF);
    apply(1'b1, 1'b1, 14'h0020, 32'hFFFFFFFF, 1'b1, 1'b1, 14'h0010, 32'hFFFFFFFF);
    check("in_reset_a", rdata_a, 32'h0);
    check("in_reset_b", rdata_b, 32'h0);
    resetn = 1'b1;
    apply(1'b1, 1'b0, 14'h0020, 32'h0, 1'b1, 1'b0, 14'h0010, 32'h0);
    check("post_reset_a", rdata_a, 32'h12345678);
    check("post_reset_b", rdata_b, 32'hDEADBEEF);

    // ---- random fill from both ports, including both boundary words -------
    apply(1'b0, 1'b1, 14'h0000, 32'hC0DE0000, 1'b0, 1'b1, 14'h3FFF, 32'hC0DE3FFF);
    for (int i = 0; i < 500; i++) begin
      ra = 14'($urandom_range(0, 16383));
      rb = 14'($urandom_range(0, 16383));
      apply(1'b0, 1'b1, ra, $urandom(), 1'b0, 1'b1, rb, $urandom());
    end
    idle();

    // ---- read back every model word on both ports -------------------------
    foreach (model[k]) keys.push_back(k);
    for (int i = 0; i < keys.size(); i++) begin
      apply(1'b1, 1'b0, 14'(keys[i]), 32'h0, 1'b1, 1'b0, 14'(keys[i]), 32'h0);
      check($sformatf("fill_a[%04h]", keys[i]), rdata_a, model[keys[i]]);
      check($sformatf("fill_b[%04h]", keys[i]), rdata_b, model[keys[i]]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_dp_32x16384
